key_cmd_arbiter: RTL and testbench

- Turns raw push-button levels into single-cycle commands and shares one command channel to the screen-saver renderer (mode/colour/speed changes).
- Each key is edge-detected and latched as a pending request.
- Pending requests are granted round-robin over a valid/ready handshake.
- A programmable hold-off after every accepted command rate-limits the renderer.

---
 rtl/key_cmd_pkg.sv | 21 ++
 rtl/key_cmd_arbiter_oneshot.sv | 35 +++
 rtl/key_cmd_arbiter.sv | 120 ++++++++++++
 tb/tb_key_cmd_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_cmd_pkg.sv
// Shared types and defaults for the key command arbiter.
package key_cmd_pkg;

   // Arbiter control states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OFFER = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   localparam int unsigned N_KEYS_DEF  = 4;
   localparam int unsigned HOLDOFF_DEF = 4;

   // Hold-off counter width: enough bits for HOLDOFF, never less than one bit
   function automatic int unsigned hold_cnt_width(input int unsigned holdoff);
      int unsigned w;
      w = 32'($clog2(holdoff + 1));
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/key_cmd_arbiter_oneshot.sv
// Per-key rising-edge detector with a sticky pending-request latch.
module key_oneshot (
   input  logic clk_i,
   input  logic reset_i,
   input  logic key_i,
   input  logic clr_i,
   output logic req_o
);

   logic key_q;
   logic req_q;
   logic rise;

   // A press is a 0->1 transition of the already-synchronised level
   assign rise = key_i & ~key_q;

   // Previous level starts high so a key held through reset must be released first;
   // a new press in the grant cycle keeps the request alive
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         key_q <= 1'b1;
         req_q <= 1'b0;
      end else begin
         key_q <= key_i;
         if (rise) begin
            req_q <= 1'b1;
         end else if (clr_i) begin
            req_q <= 1'b0;
         end
      end
   end

   assign req_o = req_q;

endmodule

// File: rtl/key_cmd_arbiter.sv
// Key-to-command arbiter: latches key presses, grants them round-robin over a
// valid/ready channel and rate-limits the renderer with a hold-off after each command.
module key_cmd_arbiter
   import key_cmd_pkg::*;
#(
   parameter  int unsigned N_KEYS  = N_KEYS_DEF,
   parameter  int unsigned HOLDOFF = HOLDOFF_DEF,
   localparam int unsigned IDW     = $clog2(N_KEYS)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [N_KEYS-1:0] key_i,
   input  logic              cmd_ready_i,
   output logic              cmd_valid_o,
   output logic [IDW-1:0]    cmd_id_o,
   output logic [N_KEYS-1:0] pending_o,
   output logic              busy_o
);

   localparam int unsigned CW        = hold_cnt_width(HOLDOFF);
   localparam int unsigned HOLD_LOAD = (HOLDOFF == 0) ? 0 : HOLDOFF - 1;

   state_e            state_q;
   logic [IDW-1:0]    cmd_id_q;
   logic [IDW-1:0]    last_grant_q;
   logic [CW-1:0]     cnt_q;
   logic              cmd_valid_q;
   logic              busy_q;

   logic [N_KEYS-1:0] req;
   logic [N_KEYS-1:0] clr;
   logic              handshake_c;
   logic [IDW-1:0]    sel_c;
   logic [IDW-1:0]    cand_c;

   // Handshake only counts while a command is actually on offer
   assign handshake_c = (state_q == ST_OFFER) & cmd_ready_i;

   // One edge detector / pending latch per key; cleared by the grant of that key
   for (genvar i = 0; i < N_KEYS; i++) begin : g_key
      assign clr[i] = handshake_c & (cmd_id_q == IDW'(i));

      key_oneshot u_oneshot (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .key_i   (key_i[i]),
         .clr_i   (clr[i]),
         .req_o   (req[i])
      );
   end

   // Round-robin pick: first pending key after the last grant, wrapping around;
   // scanning farthest-first lets the nearest hit overwrite the others
   always_comb begin
      sel_c  = '0;
      cand_c = '0;
      for (int unsigned k = N_KEYS; k >= 1; k--) begin
         cand_c = IDW'((32'(last_grant_q) + k) % N_KEYS);
         if (req[cand_c]) begin
            sel_c = cand_c;
         end
      end
   end

   // Control FSM with hold-off counter; selection is frozen for the whole offer
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= ST_IDLE;
         cmd_id_q     <= '0;
         last_grant_q <= IDW'(N_KEYS - 1);
         cnt_q        <= '0;
         cmd_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|req) begin
                  cmd_id_q    <= sel_c;
                  cmd_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= ST_OFFER;
               end
            end
            ST_OFFER: begin
               if (cmd_ready_i) begin
                  last_grant_q <= cmd_id_q;
                  cmd_valid_q  <= 1'b0;
                  if (HOLDOFF == 0) begin
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end else begin
                     cnt_q   <= CW'(HOLD_LOAD);
                     state_q <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (cnt_q == '0) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: begin
               cmd_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               cnt_q       <= '0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_valid_o = cmd_valid_q;
   assign cmd_id_o    = cmd_id_q;
   assign pending_o   = req;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_key_cmd_arbiter.sv
// Bench for key_cmd_arbiter: directed scenarios plus random traffic against a
// cycle-level behavioural model of the press/grant/hold-off rules.
module tb_key_cmd_arbiter;

   localparam int unsigned NK  = 4;
   localparam int unsigned HO  = 4;
   localparam int unsigned IDW = 2;

   logic          clk_i = 1'b0;
   logic          reset_i = 1'b1;
   logic [NK-1:0] key_i = '0;
   logic          cmd_ready_i = 1'b0;
   logic          cmd_valid_o;
   logic [IDW-1:0] cmd_id_o;
   logic [NK-1:0] pending_o;
   logic          busy_o;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned edge_cnt = 0;
   int unsigned vld_cnt  = 0;
   int unsigned bad_id   = 0;

   // Handshakes seen on the DUT channel: id and the edge index they happened on
   int unsigned g_id[$];
   int unsigned g_edge[$];

   // Reference model state
   bit [NK-1:0] m_keyq = '1;
   bit [NK-1:0] m_pend = '0;
   bit          m_offer = 1'b0;
   int unsigned m_id = 0;
   int unsigned m_last = NK - 1;
   int unsigned m_cool = 0;

   always #5 clk_i = ~clk_i;

   key_cmd_arbiter #(.N_KEYS(NK), .HOLDOFF(HO)) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .key_i       (key_i),
      .cmd_ready_i (cmd_ready_i),
      .cmd_valid_o (cmd_valid_o),
      .cmd_id_o    (cmd_id_o),
      .pending_o   (pending_o),
      .busy_o      (busy_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_cnt);
      end
   endtask

   // First pending key after 'last', wrapping
   function automatic int unsigned rr_pick(input bit [NK-1:0] p, input int unsigned last);
      for (int unsigned k = 1; k <= NK; k++) begin
         if (p[(last + k) % NK]) return (last + k) % NK;
      end
      return 0;
   endfunction

   // Advance the model by one clock edge with the inputs present at that edge
   task automatic model_step(input bit [NK-1:0] k, input bit rdy, input bit rst);
      bit [NK-1:0] np;
      bit          hs;
      if (rst) begin
         m_keyq = '1; m_pend = '0; m_offer = 1'b0; m_id = 0; m_last = NK - 1; m_cool = 0;
      end else begin
         hs = m_offer && rdy;
         np = m_pend;
         if (hs) np[m_id] = 1'b0;
         np = np | (k & ~m_keyq);
         if (m_offer) begin
            if (hs) begin
               m_offer = 1'b0;
               m_last  = m_id;
               m_cool  = HO;
            end
         end else if (m_cool > 0) begin
            m_cool--;
         end else if (m_pend != '0) begin
            m_offer = 1'b1;
            m_id    = rr_pick(m_pend, m_last);
         end
         m_pend = np;
         m_keyq = k;
      end
   endtask

   // Apply inputs on the falling edge, step model on the rising edge, compare just after
   task automatic cycle(input logic [NK-1:0] k, input logic rdy, input logic rst);
      @(negedge clk_i);
      key_i = k; cmd_ready_i = rdy; reset_i = rst;
      if (!rst && cmd_valid_o && rdy) begin
         g_id.push_back(32'(cmd_id_o));
         g_edge.push_back(edge_cnt + 1);
      end
      @(posedge clk_i);
      edge_cnt++;
      model_step(k, rdy, rst);
      #1;
      if (cmd_valid_o) begin
         vld_cnt++;
         if (cmd_id_o != 2'd1) bad_id++;
      end
      check_eq("cmd_valid", 32'(cmd_valid_o), 32'(m_offer));
      check_eq("cmd_id",    32'(cmd_id_o),    m_id);
      check_eq("pending",   32'(pending_o),   32'(m_pend));
      check_eq("busy",      32'(busy_o),      32'(m_offer || (m_cool != 0)));
   endtask

   task automatic do_reset();
      cycle('0, 1'b0, 1'b1);
      cycle('0, 1'b0, 1'b1);
      cycle('0, 1'b0, 1'b0);
      g_id.delete();
      g_edge.delete();
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cycle('0, 1'b1, 1'b0);
   endtask

   function automatic logic [31:0] gid_at(input int unsigned k);
      return (k < g_id.size()) ? 32'(g_id[k]) : 32'hDEAD;
   endfunction

   function automatic logic [31:0] gedge_at(input int unsigned k);
      return (k < g_edge.size()) ? 32'(g_edge[k]) : 32'hDEAD;
   endfunction

   initial begin
      int unsigned e0;
      logic [NK-1:0] kk;

      // Reset state
      do_reset();
      check_eq("rst_valid", 32'(cmd_valid_o), 32'd0);
      check_eq("rst_pending", 32'(pending_o), 32'd0);
      check_eq("rst_busy", 32'(busy_o), 32'd0);
      check_eq("rst_id", 32'(cmd_id_o), 32'd0);

      // Single press held 10 cycles: one command, two edges after first sample
      e0 = edge_cnt + 1;
      for (int i = 0; i < 10; i++) cycle(4'b0001, 1'b1, 1'b0);
      idle(6);
      check_eq("single_cnt", 32'(g_id.size()), 32'd1);
      check_eq("single_id", gid_at(0), 32'd0);
      check_eq("single_edge", gedge_at(0), 32'(e0 + 2));
      check_eq("single_pend", 32'(pending_o), 32'd0);

      // All keys at once: ids 0..3 spaced HOLDOFF+2
      do_reset();
      e0 = edge_cnt + 1;
      cycle(4'b1111, 1'b1, 1'b0);
      idle(30);
      check_eq("all_cnt", 32'(g_id.size()), 32'd4);
      for (int unsigned k = 0; k < 4; k++) begin
         check_eq("all_id", gid_at(k), 32'(k));
         check_eq("all_edge", gedge_at(k), 32'(e0 + 2 + 6 * k));
      end

      // Round-robin wrap after grant of id 2
      do_reset();
      cycle(4'b0100, 1'b1, 1'b0);
      idle(10);
      cycle(4'b1001, 1'b1, 1'b0);
      idle(20);
      check_eq("rr_cnt", 32'(g_id.size()), 32'd3);
      check_eq("rr_id0", gid_at(0), 32'd2);
      check_eq("rr_id1", gid_at(1), 32'd3);
      check_eq("rr_id2", gid_at(2), 32'd0);

      // Backpressure: key 1 offered 8 cycles, key 0 pressed meanwhile is served next
      do_reset();
      e0 = edge_cnt + 1;
      cycle(4'b0010, 1'b0, 1'b0);
      vld_cnt = 0; bad_id = 0;
      cycle(4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) cycle((i == 2) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
      check_eq("bp_valid_len", 32'(vld_cnt), 32'd8);
      check_eq("bp_id_stable", 32'(bad_id), 32'd0);
      cycle(4'b0000, 1'b1, 1'b0);
      idle(15);
      check_eq("bp_cnt", 32'(g_id.size()), 32'd2);
      check_eq("bp_id0", gid_at(0), 32'd1);
      check_eq("bp_edge0", gedge_at(0), 32'(e0 + 9));
      check_eq("bp_id1", gid_at(1), 32'd0);

      // Second press while still pending is absorbed
      do_reset();
      cycle(4'b0100, 1'b0, 1'b0);
      cycle(4'b0000, 1'b0, 1'b0);
      cycle(4'b0100, 1'b0, 1'b0);
      cycle(4'b0000, 1'b0, 1'b0);
      cycle(4'b0000, 1'b1, 1'b0);
      idle(20);
      check_eq("absorb_cnt", 32'(g_id.size()), 32'd1);
      check_eq("absorb_id", gid_at(0), 32'd2);

      // Re-press in the handshake cycle survives the clear
      do_reset();
      e0 = edge_cnt + 1;
      cycle(4'b0100, 1'b0, 1'b0);
      cycle(4'b0000, 1'b0, 1'b0);
      cycle(4'b0100, 1'b1, 1'b0);
      idle(20);
      check_eq("repress_cnt", 32'(g_id.size()), 32'd2);
      check_eq("repress_id1", gid_at(1), 32'd2);
      check_eq("repress_edge0", gedge_at(0), 32'(e0 + 2));
      check_eq("repress_edge1", gedge_at(1), 32'(e0 + 8));

      // Key held through reset release: nothing until released and pressed again
      cycle(4'b1000, 1'b1, 1'b1);
      cycle(4'b1000, 1'b1, 1'b1);
      g_id.delete(); g_edge.delete();
      for (int i = 0; i < 10; i++) cycle(4'b1000, 1'b1, 1'b0);
      check_eq("held_none", 32'(g_id.size()), 32'd0);
      cycle(4'b0000, 1'b1, 1'b0);
      e0 = edge_cnt + 1;
      cycle(4'b1000, 1'b1, 1'b0);
      idle(10);
      check_eq("held_cnt", 32'(g_id.size()), 32'd1);
      check_eq("held_id", gid_at(0), 32'd3);
      check_eq("held_edge", gedge_at(0), 32'(e0 + 2));

      // Reset during an offer drops it
      do_reset();
      cycle(4'b0010, 1'b0, 1'b0);
      cycle(4'b0100, 1'b0, 1'b0);
      check_eq("mid_offer_valid", 32'(cmd_valid_o), 32'd1);
      cycle(4'b0000, 1'b0, 1'b1);
      check_eq("mid_rst_valid", 32'(cmd_valid_o), 32'd0);
      check_eq("mid_rst_pending", 32'(pending_o), 32'd0);
      idle(8);
      check_eq("mid_rst_none", 32'(g_id.size()), 32'd0);

      // Random traffic against the model
      kk = '0;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < int'(NK); b++) begin
            if ($urandom_range(0, 7) == 0) kk[b] = ~kk[b];
         end
         cycle(kk, 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 299) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
